// File: rtl/axil_demux_n_if.sv
// AXI-Lite 1-to-N demux bus bundle: one upstream AXI-Lite port (s_*) plus
// N downstream channels packed side by side (m_*). The "slave" modport is
// the demux view; "master" is the view of whatever surrounds it.
interface axil_demux_n_if #(
    parameter int num_slaves_p = 4,
    parameter int data_width_p = 32
);
    localparam int n_c = num_slaves_p;
    localparam int d_c = data_width_p;
    localparam int s_c = data_width_p / 8;

    logic [31:0]         s_awaddr;
    logic                s_awvalid;
    logic                s_awready;
    logic [d_c-1:0]      s_wdata;
    logic [s_c-1:0]      s_wstrb;
    logic                s_wvalid;
    logic                s_wready;
    logic [1:0]          s_bresp;
    logic                s_bvalid;
    logic                s_bready;
    logic [31:0]         s_araddr;
    logic                s_arvalid;
    logic                s_arready;
    logic [d_c-1:0]      s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rvalid;
    logic                s_rready;

    logic [n_c*32-1:0]   m_awaddr;
    logic [n_c-1:0]      m_awvalid;
    logic [n_c-1:0]      m_awready;
    logic [n_c*d_c-1:0]  m_wdata;
    logic [n_c*s_c-1:0]  m_wstrb;
    logic [n_c-1:0]      m_wvalid;
    logic [n_c-1:0]      m_wready;
    logic [n_c*2-1:0]    m_bresp;
    logic [n_c-1:0]      m_bvalid;
    logic [n_c-1:0]      m_bready;
    logic [n_c*32-1:0]   m_araddr;
    logic [n_c-1:0]      m_arvalid;
    logic [n_c-1:0]      m_arready;
    logic [n_c*d_c-1:0]  m_rdata;
    logic [n_c*2-1:0]    m_rresp;
    logic [n_c-1:0]      m_rvalid;
    logic [n_c-1:0]      m_rready;

    modport slave (
        input  s_awaddr, s_awvalid, output s_awready,
        input  s_wdata, s_wstrb, s_wvalid, output s_wready,
        output s_bresp, s_bvalid, input s_bready,
        input  s_araddr, s_arvalid, output s_arready,
        output s_rdata, s_rresp, s_rvalid, input s_rready,
        output m_awaddr, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wvalid, input m_wready,
        input  m_bresp, m_bvalid, output m_bready,
        output m_araddr, m_arvalid, input m_arready,
        input  m_rdata, m_rresp, m_rvalid, output m_rready
    );

    modport master (
        output s_awaddr, s_awvalid, input s_awready,
        output s_wdata, s_wstrb, s_wvalid, input s_wready,
        input  s_bresp, s_bvalid, output s_bready,
        output s_araddr, s_arvalid, input s_arready,
        input  s_rdata, s_rresp, s_rvalid, output s_rready,
        input  m_awaddr, m_awvalid, output m_awready,
        input  m_wdata, m_wstrb, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready,
        input  m_araddr, m_arvalid, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready
    );
endinterface

// File: rtl/axil_demux_n.sv
// AXI-Lite 1-to-N address-decoding demux. One outstanding write and one
// outstanding read, on independent paths. Unmapped addresses get DECERR,
// a silent channel gets SLVERR after timeout_p cycles, and late responses
// from a timed-out channel are drained (stale bits) instead of forwarded.
module axil_demux_n #(
    parameter int          num_slaves_p      = 4,
    parameter int          data_width_p      = 32,
    parameter int          slot_addr_width_p = 8,
    parameter logic [31:0] base_addr_p       = 32'h0,
    parameter int          timeout_p         = 255,
    parameter logic [31:0] err_data_p        = 32'hDEADBEEF
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    axil_demux_n_if.slave bus
);
    localparam int n_c  = num_slaves_p;
    localparam int d_c  = data_width_p;
    localparam int s_c  = data_width_p / 8;
    localparam int iw_c = (n_c > 1) ? $clog2(n_c) : 1;
    localparam int cw_c = (timeout_p > 1) ? $clog2(timeout_p + 1) : 1;
    localparam logic [cw_c-1:0] to_last_c   = (timeout_p > 0) ? cw_c'(timeout_p - 1) : '0;
    localparam logic [d_c-1:0]  err_rdata_c = d_c'(err_data_p);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ISSUE = 2'd1, W_RESP = 2'd2, W_B = 2'd3} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ISSUE = 2'd1, R_RESP = 2'd2, R_R = 2'd3} r_state_t;

    // Returns {hit, channel index} for an address.
    function automatic logic [iw_c:0] decode(input logic [31:0] addr);
        logic [31:0] slot;
        slot = (addr - base_addr_p) >> slot_addr_width_p;
        return {(addr >= base_addr_p) && (slot < 32'(n_c)), slot[iw_c-1:0]};
    endfunction

    // write path state
    w_state_t          w_state_r, w_state_nx;
    logic              aw_held_r, w_held_r, aw_done_r, w_done_r, aw_hit_r;
    logic [31:0]       awaddr_r;
    logic [d_c-1:0]    wdata_r;
    logic [s_c-1:0]    wstrb_r;
    logic [iw_c-1:0]   aw_idx_r;
    logic [1:0]        bresp_r, bresp_nx;
    logic [cw_c-1:0]   wcnt_r;
    logic [n_c-1:0]    stale_w_r, stale_w_set_s;
    logic [n_c-1:0]    m_awvalid_s, m_wvalid_s, m_bready_s;
    logic              aw_hs_s, w_hs_s, aw_ok_s, w_ok_s, w_to_s, awready_s, wready_s;
    logic [iw_c:0]     aw_dec_s;

    // read path state
    r_state_t          r_state_r, r_state_nx;
    logic [31:0]       araddr_r;
    logic [iw_c-1:0]   ar_idx_r;
    logic [d_c-1:0]    rdata_r, rdata_nx;
    logic [1:0]        rresp_r, rresp_nx;
    logic [cw_c-1:0]   rcnt_r;
    logic [n_c-1:0]    stale_r_r, stale_r_set_s;
    logic [n_c-1:0]    m_arvalid_s, m_rready_s;
    logic              ar_hs_s, r_to_s, arready_s;
    logic [iw_c:0]     ar_dec_s;

    assign aw_dec_s  = decode(bus.s_awaddr);
    assign ar_dec_s  = decode(bus.s_araddr);
    assign awready_s = reset_n_i && (w_state_r == W_IDLE) && !aw_held_r;
    assign wready_s  = reset_n_i && (w_state_r == W_IDLE) && !w_held_r;
    assign arready_s = reset_n_i && (r_state_r == R_IDLE);
    assign w_to_s    = (timeout_p != 0) && (wcnt_r == to_last_c);
    assign r_to_s    = (timeout_p != 0) && (rcnt_r == to_last_c);

    // Write path: next state, selected channel valids/readies, handshake strobes.
    always_comb begin
        w_state_nx    = w_state_r;
        bresp_nx      = bresp_r;
        m_awvalid_s   = '0;
        m_wvalid_s    = '0;
        m_bready_s    = stale_w_r;
        stale_w_set_s = '0;
        aw_hs_s       = 1'b0;
        w_hs_s        = 1'b0;
        aw_ok_s       = 1'b0;
        w_ok_s        = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                aw_hs_s = bus.s_awvalid && awready_s;
                w_hs_s  = bus.s_wvalid && wready_s;
                if ((aw_held_r || aw_hs_s) && (w_held_r || w_hs_s)) begin
                    if (aw_held_r ? aw_hit_r : aw_dec_s[iw_c]) begin
                        w_state_nx = W_ISSUE;
                    end else begin
                        w_state_nx = W_B;
                        bresp_nx   = 2'b11;
                    end
                end else begin
                    w_state_nx = W_IDLE;
                end
            end
            W_ISSUE: begin
                // a channel still draining a stale response is not addressed
                if (!stale_w_r[aw_idx_r]) begin
                    m_awvalid_s[aw_idx_r] = !aw_done_r;
                    m_wvalid_s[aw_idx_r]  = !w_done_r;
                end else begin
                    m_awvalid_s = '0;
                end
                aw_ok_s = aw_done_r || (m_awvalid_s[aw_idx_r] && bus.m_awready[aw_idx_r]);
                w_ok_s  = w_done_r || (m_wvalid_s[aw_idx_r] && bus.m_wready[aw_idx_r]);
                if (aw_ok_s && w_ok_s) begin
                    w_state_nx = W_RESP;
                end else if (w_to_s) begin
                    w_state_nx = W_B;
                    bresp_nx   = 2'b10;
                end else begin
                    w_state_nx = W_ISSUE;
                end
            end
            W_RESP: begin
                m_bready_s[aw_idx_r] = 1'b1;
                if (bus.m_bvalid[aw_idx_r]) begin
                    w_state_nx = W_B;
                    bresp_nx   = bus.m_bresp[{aw_idx_r, 1'b0} +: 2];
                end else if (w_to_s) begin
                    w_state_nx              = W_B;
                    bresp_nx                = 2'b10;
                    stale_w_set_s[aw_idx_r] = 1'b1;
                end else begin
                    w_state_nx = W_RESP;
                end
            end
            W_B: begin
                if (bus.s_bready) begin
                    w_state_nx = W_IDLE;
                end else begin
                    w_state_nx = W_B;
                end
            end
            default: begin
                w_state_nx = W_IDLE;
            end
        endcase
    end

    // Write path registers: state, captured AW/W, issue progress, timeout, stale.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_state_r <= W_IDLE;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            aw_hit_r  <= 1'b0;
            aw_idx_r  <= '0;
            awaddr_r  <= 32'h0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            bresp_r   <= 2'b00;
            wcnt_r    <= '0;
            stale_w_r <= '0;
        end else begin
            w_state_r <= w_state_nx;
            bresp_r   <= bresp_nx;
            aw_done_r <= (w_state_r == W_ISSUE) && aw_ok_s;
            w_done_r  <= (w_state_r == W_ISSUE) && w_ok_s;
            stale_w_r <= (stale_w_r & ~bus.m_bvalid) | stale_w_set_s;
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                awaddr_r  <= bus.s_awaddr;
                aw_idx_r  <= aw_dec_s[iw_c-1:0];
                aw_hit_r  <= aw_dec_s[iw_c];
            end else if ((w_state_r == W_B) && bus.s_bready) begin
                aw_held_r <= 1'b0;
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                wdata_r  <= bus.s_wdata;
                wstrb_r  <= bus.s_wstrb;
            end else if ((w_state_r == W_B) && bus.s_bready) begin
                w_held_r <= 1'b0;
            end
            if ((w_state_r == W_ISSUE) || (w_state_r == W_RESP)) begin
                if (wcnt_r != to_last_c) begin
                    wcnt_r <= wcnt_r + cw_c'(1);
                end
            end else begin
                wcnt_r <= '0;
            end
        end
    end

    // Read path: next state, selected channel valid/ready, response capture.
    always_comb begin
        r_state_nx    = r_state_r;
        rdata_nx      = rdata_r;
        rresp_nx      = rresp_r;
        m_arvalid_s   = '0;
        m_rready_s    = stale_r_r;
        stale_r_set_s = '0;
        ar_hs_s       = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                ar_hs_s = bus.s_arvalid && arready_s;
                if (ar_hs_s && ar_dec_s[iw_c]) begin
                    r_state_nx = R_ISSUE;
                end else if (ar_hs_s) begin
                    r_state_nx = R_R;
                    rresp_nx   = 2'b11;
                    rdata_nx   = err_rdata_c;
                end else begin
                    r_state_nx = R_IDLE;
                end
            end
            R_ISSUE: begin
                m_arvalid_s[ar_idx_r] = !stale_r_r[ar_idx_r];
                if (m_arvalid_s[ar_idx_r] && bus.m_arready[ar_idx_r]) begin
                    r_state_nx = R_RESP;
                end else if (r_to_s) begin
                    r_state_nx = R_R;
                    rresp_nx   = 2'b10;
                    rdata_nx   = err_rdata_c;
                end else begin
                    r_state_nx = R_ISSUE;
                end
            end
            R_RESP: begin
                m_rready_s[ar_idx_r] = 1'b1;
                if (bus.m_rvalid[ar_idx_r]) begin
                    r_state_nx = R_R;
                    rresp_nx   = bus.m_rresp[{ar_idx_r, 1'b0} +: 2];
                    rdata_nx   = bus.m_rdata[32'(ar_idx_r) * d_c +: d_c];
                end else if (r_to_s) begin
                    r_state_nx              = R_R;
                    rresp_nx                = 2'b10;
                    rdata_nx                = err_rdata_c;
                    stale_r_set_s[ar_idx_r] = 1'b1;
                end else begin
                    r_state_nx = R_RESP;
                end
            end
            R_R: begin
                if (bus.s_rready) begin
                    r_state_nx = R_IDLE;
                end else begin
                    r_state_nx = R_R;
                end
            end
            default: begin
                r_state_nx = R_IDLE;
            end
        endcase
    end

    // Read path registers: state, captured AR, response data, timeout, stale.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state_r <= R_IDLE;
            araddr_r  <= 32'h0;
            ar_idx_r  <= '0;
            rdata_r   <= '0;
            rresp_r   <= 2'b00;
            rcnt_r    <= '0;
            stale_r_r <= '0;
        end else begin
            r_state_r <= r_state_nx;
            rdata_r   <= rdata_nx;
            rresp_r   <= rresp_nx;
            stale_r_r <= (stale_r_r & ~bus.m_rvalid) | stale_r_set_s;
            if (ar_hs_s) begin
                araddr_r <= bus.s_araddr;
                ar_idx_r <= ar_dec_s[iw_c-1:0];
            end
            if ((r_state_r == R_ISSUE) || (r_state_r == R_RESP)) begin
                if (rcnt_r != to_last_c) begin
                    rcnt_r <= rcnt_r + cw_c'(1);
                end
            end else begin
                rcnt_r <= '0;
            end
        end
    end

    assign bus.s_awready = awready_s;
    assign bus.s_wready  = wready_s;
    assign bus.s_bvalid  = (w_state_r == W_B);
    assign bus.s_bresp   = bresp_r;
    assign bus.s_arready = arready_s;
    assign bus.s_rvalid  = (r_state_r == R_R);
    assign bus.s_rresp   = rresp_r;
    assign bus.s_rdata   = rdata_r;

    assign bus.m_awaddr  = {n_c{awaddr_r}};
    assign bus.m_awvalid = m_awvalid_s;
    assign bus.m_wdata   = {n_c{wdata_r}};
    assign bus.m_wstrb   = {n_c{wstrb_r}};
    assign bus.m_wvalid  = m_wvalid_s;
    assign bus.m_bready  = m_bready_s;
    assign bus.m_araddr  = {n_c{araddr_r}};
    assign bus.m_arvalid = m_arvalid_s;
    assign bus.m_rready  = m_rready_s;
endmodule

// File: tb/tb_axil_demux_n.sv
// Directed bench for axil_demux_n: N=4, 32-bit data, 256-byte slots at 0,
// timeout of 8 cycles. Downstream channels are driven by hand per scenario.
module tb_axil_demux_n;
    logic clk_i;
    logic reset_n_i;
    int   vectors;
    int   miscompares;

    axil_demux_n_if #(.num_slaves_p(4), .data_width_p(32)) bus ();

    axil_demux_n #(
        .num_slaves_p(4), .data_width_p(32), .slot_addr_width_p(8),
        .base_addr_p(32'h0), .timeout_p(8), .err_data_p(32'hDEADBEEF)
    ) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .bus(bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.s_awaddr = 32'h0; bus.s_awvalid = 1'b0;
        bus.s_wdata = 32'h0; bus.s_wstrb = 4'h0; bus.s_wvalid = 1'b0;
        bus.s_bready = 1'b1;
        bus.s_araddr = 32'h0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b1;
        bus.m_awready = 4'b0000; bus.m_wready = 4'b0000;
        bus.m_bresp = 8'h00; bus.m_bvalid = 4'b0000;
        bus.m_arready = 4'b0000;
        bus.m_rdata = 128'h0; bus.m_rresp = 8'h00; bus.m_rvalid = 4'b0000;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        idle_inputs();
        #12;
        vectors++; if (bus.s_awready !== 1'b0 || bus.s_wready !== 1'b0 || bus.s_arready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b%b%b exp 000", bus.s_awready, bus.s_wready, bus.s_arready); end
        step();
        reset_n_i = 1'b1;
        #1;
        vectors++; if (bus.s_awready !== 1'b1 || bus.s_wready !== 1'b1 || bus.s_arready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_out got %b%b%b exp 111", bus.s_awready, bus.s_wready, bus.s_arready); end
        vectors++; if (bus.s_bvalid !== 1'b0 || bus.s_rvalid !== 1'b0 || bus.m_awvalid !== 4'b0 || bus.m_wvalid !== 4'b0 || bus.m_arvalid !== 4'b0) begin miscompares++; $display("FAIL rst_valids got b%b r%b aw%b w%b ar%b exp all 0", bus.s_bvalid, bus.s_rvalid, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid); end
        vectors++; if (bus.s_bresp !== 2'b00 || bus.s_rresp !== 2'b00 || bus.s_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_resp got %b %b %h exp 00 00 0", bus.s_bresp, bus.s_rresp, bus.s_rdata); end
    endtask

    task automatic test_write_same_cycle();
        bus.s_awaddr = 32'h0000_0204; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'h1122_3344; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        step();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        vectors++; if (bus.m_awvalid !== 4'b0100 || bus.m_wvalid !== 4'b0100) begin miscompares++; $display("FAIL t1_issue got aw%b w%b exp 0100", bus.m_awvalid, bus.m_wvalid); end
        vectors++; if (bus.m_awaddr[95:64] !== 32'h0000_0204 || bus.m_wdata[95:64] !== 32'h1122_3344 || bus.m_wstrb[11:8] !== 4'hF) begin miscompares++; $display("FAIL t1_payload got %h %h %h exp 00000204 11223344 f", bus.m_awaddr[95:64], bus.m_wdata[95:64], bus.m_wstrb[11:8]); end
        bus.m_awready = 4'b0100; bus.m_wready = 4'b0100;
        step();
        bus.m_awready = 4'b0000; bus.m_wready = 4'b0000;
        vectors++; if (bus.m_awvalid !== 4'b0000 || bus.m_bready !== 4'b0100 || bus.s_bvalid !== 1'b0) begin miscompares++; $display("FAIL t1_resp_wait got aw%b bready%b bv%b exp 0000 0100 0", bus.m_awvalid, bus.m_bready, bus.s_bvalid); end
        bus.m_bvalid = 4'b0100; bus.m_bresp = 8'h00;
        step();
        bus.m_bvalid = 4'b0000;
        vectors++; if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b00) begin miscompares++; $display("FAIL t1_bresp got v%b r%b exp 1 00", bus.s_bvalid, bus.s_bresp); end
        step();
        vectors++; if (bus.s_bvalid !== 1'b0 || bus.s_awready !== 1'b1) begin miscompares++; $display("FAIL t1_done got bv%b awr%b exp 0 1", bus.s_bvalid, bus.s_awready); end
    endtask

    task automatic test_w_before_aw();
        bus.s_wdata = 32'h5555_AAAA; bus.s_wstrb = 4'h3; bus.s_wvalid = 1'b1;
        step();
        bus.s_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.s_wready !== 1'b0 || bus.s_awready !== 1'b1 || bus.m_wvalid !== 4'b0 || bus.m_awvalid !== 4'b0) begin miscompares++; $display("FAIL t2_hold%0d got wr%b awr%b w%b aw%b exp 0 1 0000 0000", i, bus.s_wready, bus.s_awready, bus.m_wvalid, bus.m_awvalid); end
            if (i < 2) step();
        end
        bus.s_awaddr = 32'h0000_0010; bus.s_awvalid = 1'b1;
        step();
        bus.s_awvalid = 1'b0;
        vectors++; if (bus.m_awvalid !== 4'b0001 || bus.m_wvalid !== 4'b0001 || bus.m_wdata[31:0] !== 32'h5555_AAAA) begin miscompares++; $display("FAIL t2_issue got aw%b w%b d%h exp 0001 0001 5555aaaa", bus.m_awvalid, bus.m_wvalid, bus.m_wdata[31:0]); end
        bus.m_wready = 4'b0001;
        step();
        bus.m_wready = 4'b0000;
        vectors++; if (bus.m_wvalid !== 4'b0000 || bus.m_awvalid !== 4'b0001) begin miscompares++; $display("FAIL t2_split got w%b aw%b exp 0000 0001", bus.m_wvalid, bus.m_awvalid); end
        bus.m_awready = 4'b0001;
        step();
        bus.m_awready = 4'b0000;
        vectors++; if (bus.m_awvalid !== 4'b0000 || bus.m_bready !== 4'b0001) begin miscompares++; $display("FAIL t2_resp_wait got aw%b bready%b exp 0000 0001", bus.m_awvalid, bus.m_bready); end
        bus.m_bvalid = 4'b0001; bus.m_bresp = 8'h00;
        step();
        bus.m_bvalid = 4'b0000;
        vectors++; if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b00) begin miscompares++; $display("FAIL t2_bresp got v%b r%b exp 1 00", bus.s_bvalid, bus.s_bresp); end
        step();
    endtask

    task automatic test_read_decerr();
        bus.s_araddr = 32'h0000_0500; bus.s_arvalid = 1'b1;
        step();
        bus.s_arvalid = 1'b0;
        vectors++; if (bus.m_arvalid !== 4'b0000) begin miscompares++; $display("FAIL t3_no_issue got %b exp 0000", bus.m_arvalid); end
        vectors++; if (bus.s_rvalid !== 1'b1 || bus.s_rresp !== 2'b11 || bus.s_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL t3_decerr got v%b r%b d%h exp 1 11 deadbeef", bus.s_rvalid, bus.s_rresp, bus.s_rdata); end
        step();
        vectors++; if (bus.s_rvalid !== 1'b0) begin miscompares++; $display("FAIL t3_done got %b exp 0", bus.s_rvalid); end
    endtask

    task automatic test_read_timeout();
        int n;
        bus.s_rready = 1'b0;
        bus.s_araddr = 32'h0000_0104; bus.s_arvalid = 1'b1;
        step();
        bus.s_arvalid = 1'b0;
        vectors++; if (bus.m_arvalid !== 4'b0010 || bus.m_araddr[63:32] !== 32'h0000_0104) begin miscompares++; $display("FAIL t4_issue got %b %h exp 0010 00000104", bus.m_arvalid, bus.m_araddr[63:32]); end
        bus.m_arready = 4'b0010;
        step();
        bus.m_arready = 4'b0000;
        vectors++; if (bus.m_rready !== 4'b0010 || bus.m_arvalid !== 4'b0000) begin miscompares++; $display("FAIL t4_resp_wait got rr%b ar%b exp 0010 0000", bus.m_rready, bus.m_arvalid); end
        n = 1;
        while (bus.s_rvalid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++; if (n != 8) begin miscompares++; $display("FAIL t4_latency got %0d exp 8", n); end
        vectors++; if (bus.s_rvalid !== 1'b1 || bus.s_rresp !== 2'b10 || bus.s_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL t4_slverr got v%b r%b d%h exp 1 10 deadbeef", bus.s_rvalid, bus.s_rresp, bus.s_rdata); end
        vectors++; if (bus.m_rready !== 4'b0010) begin miscompares++; $display("FAIL t4_stale got %b exp 0010", bus.m_rready); end
        bus.s_rready = 1'b1;
        step();
        vectors++; if (bus.s_rvalid !== 1'b0 || bus.m_rready !== 4'b0010) begin miscompares++; $display("FAIL t4_done got v%b rr%b exp 0 0010", bus.s_rvalid, bus.m_rready); end
    endtask

    task automatic test_stale_drain();
        bus.s_araddr = 32'h0000_0108; bus.s_arvalid = 1'b1;
        step();
        bus.s_arvalid = 1'b0;
        vectors++; if (bus.m_arvalid !== 4'b0000) begin miscompares++; $display("FAIL t5_blocked got %b exp 0000", bus.m_arvalid); end
        bus.m_rvalid = 4'b0010; bus.m_rdata[63:32] = 32'hBAD0_BAD0; bus.m_rresp = 8'h00;
        step();
        bus.m_rvalid = 4'b0000;
        vectors++; if (bus.s_rvalid !== 1'b0 || bus.m_rready !== 4'b0000) begin miscompares++; $display("FAIL t5_drain got v%b rr%b exp 0 0000", bus.s_rvalid, bus.m_rready); end
        vectors++; if (bus.m_arvalid !== 4'b0010) begin miscompares++; $display("FAIL t5_unblocked got %b exp 0010", bus.m_arvalid); end
        bus.m_arready = 4'b0010;
        step();
        bus.m_arready = 4'b0000;
        bus.m_rvalid = 4'b0010; bus.m_rdata[63:32] = 32'hCAFE_0001; bus.m_rresp = 8'h00;
        step();
        bus.m_rvalid = 4'b0000;
        vectors++; if (bus.s_rvalid !== 1'b1 || bus.s_rresp !== 2'b00 || bus.s_rdata !== 32'hCAFE_0001) begin miscompares++; $display("FAIL t5_okay got v%b r%b d%h exp 1 00 cafe0001", bus.s_rvalid, bus.s_rresp, bus.s_rdata); end
        step();
    endtask

    task automatic test_concurrent_reset();
        bus.s_bready = 1'b0; bus.s_rready = 1'b0;
        bus.s_awaddr = 32'h0000_0300; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'h0BAD_F00D; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        bus.s_araddr = 32'h0000_0004; bus.s_arvalid = 1'b1;
        step();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        vectors++; if (bus.m_awvalid !== 4'b1000 || bus.m_wvalid !== 4'b1000 || bus.m_arvalid !== 4'b0001) begin miscompares++; $display("FAIL t6_issue got aw%b w%b ar%b exp 1000 1000 0001", bus.m_awvalid, bus.m_wvalid, bus.m_arvalid); end
        bus.m_awready = 4'b1000; bus.m_wready = 4'b1000; bus.m_arready = 4'b0001;
        step();
        bus.m_awready = 4'b0000; bus.m_wready = 4'b0000; bus.m_arready = 4'b0000;
        bus.m_bvalid = 4'b1000; bus.m_bresp = 8'b10_00_00_00;
        bus.m_rvalid = 4'b0001; bus.m_rdata[31:0] = 32'hA5A5_0000; bus.m_rresp = 8'h00;
        step();
        bus.m_bvalid = 4'b0000; bus.m_rvalid = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b10 || bus.s_rvalid !== 1'b1 || bus.s_rresp !== 2'b00 || bus.s_rdata !== 32'hA5A5_0000) begin miscompares++; $display("FAIL t6_hold%0d got bv%b b%b rv%b r%b d%h exp 1 10 1 00 a5a50000", i, bus.s_bvalid, bus.s_bresp, bus.s_rvalid, bus.s_rresp, bus.s_rdata); end
            step();
        end
        reset_n_i = 1'b0;
        #1;
        vectors++; if (bus.s_bvalid !== 1'b0 || bus.s_rvalid !== 1'b0 || bus.s_awready !== 1'b0 || bus.s_arready !== 1'b0) begin miscompares++; $display("FAIL t6_async_rst got bv%b rv%b awr%b arr%b exp 0 0 0 0", bus.s_bvalid, bus.s_rvalid, bus.s_awready, bus.s_arready); end
        bus.s_bready = 1'b1; bus.s_rready = 1'b1;
        step();
        reset_n_i = 1'b1;
        step();
        vectors++; if (bus.s_awready !== 1'b1 || bus.s_bvalid !== 1'b0 || bus.s_rvalid !== 1'b0 || bus.s_bresp !== 2'b00 || bus.s_rdata !== 32'h0) begin miscompares++; $display("FAIL t6_after_rst got awr%b bv%b rv%b b%b d%h exp 1 0 0 00 0", bus.s_awready, bus.s_bvalid, bus.s_rvalid, bus.s_bresp, bus.s_rdata); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read_decerr();
        test_read_timeout();
        test_stale_drain();
        test_concurrent_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axil_demux_n.md
Name: axil_demux_n

Overview:
- Native AXI-Lite 1-to-N address-decoding demultiplexer. It feeds N per-channel AXI-Lite endpoints, such as the fsb/mcl adapters, without a vendor crossbar IP.
- Parametrised in channel count, data width, slot size and base address.
- Adds DECERR for unmapped addresses, a per-transaction response timeout returning SLVERR, and draining of stale late responses.
- One outstanding write and one outstanding read; the write and read paths are fully independent.

Parameters:
num_slaves_p, 4, number of master channels N (1..16)
data_width_p, 32, AXI-Lite data width (32 or 64); strobe width is data_width_p/8
slot_addr_width_p, 8, log2 bytes per channel region
base_addr_p, 32'h0, address of channel 0; channel j spans base + j*2^slot_addr_width_p
timeout_p, 255, cycles to wait for a downstream handshake/response; 0 disables the timeout
err_data_p, 32'hDEADBEEF, rdata returned on DECERR/SLVERR, zero-extended to data_width_p

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
s_awaddr/s_awvalid/s_awready  in/in/out  32/1/1  slave write address
s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  D/D/8/1/1  slave write data
s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  slave write response
s_araddr/s_arvalid/s_arready  in/in/out  32/1/1  slave read address
s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  D/2/1/1  slave read data
m_awaddr/m_awvalid/m_awready  out/out/in  N*32/N/N  per-channel write address (full address forwarded)
m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  N*D/N*D/8/N/N  per-channel write data
m_bresp/m_bvalid/m_bready  in/in/out  N*2/N/N  per-channel write response
m_araddr/m_arvalid/m_arready  out/out/in  N*32/N/N  per-channel read address
m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  N*D/N*2/N/N  per-channel read data

Behaviour:
- Decode: hit iff addr >= base_addr_p and idx = (addr-base_addr_p)>>slot_addr_width_p < N. idx is registered at capture.
- Write FSM states: W_IDLE, W_ISSUE, W_RESP, W_B.
  - W_IDLE: s_awready = !aw_held; s_wready = !w_held. AW and W are captured independently, in either order or in the same cycle.
  - When both are held, the next state is W_ISSUE on a hit, or W_B with bresp=2'b11 on a miss. Both held in cycle c gives m_awvalid[idx] or s_bvalid in cycle c+1.
  - W_ISSUE: m_awvalid[idx] and m_wvalid[idx] each stay high until their own ready is seen. Move to W_RESP once both have completed.
  - W_RESP: m_bready[idx]=1. On m_bvalid[idx], latch bresp and go to W_B.
  - W_B: s_bvalid=1 until s_bready, then return to W_IDLE and clear aw_held/w_held.
- Read FSM states: R_IDLE, R_ISSUE, R_RESP, R_R.
  - R_IDLE: s_arready=1; capture on handshake.
  - A miss goes to R_R with rresp=2'b11 and rdata=err_data_p. A hit goes to R_ISSUE (m_arvalid[idx] until m_arready).
  - R_RESP: m_rready[idx]=1; latch rdata/rresp.
  - R_R: s_rvalid until s_rready.
- Timeout:
  - A per-path counter resets on entering ISSUE and counts in ISSUE+RESP.
  - When it reaches timeout_p, the path goes to W_B/R_R with resp=2'b10 (rdata=err_data_p), and all m_*valid for that path drop.
  - If the timeout fires while still in ISSUE, no stale bit is set. If it fires in RESP, stale_w[idx] or stale_r[idx] is set.
- Stale drain: m_bready[j] is also high while stale_w[j]=1. A late m_bvalid[j] is consumed, never forwarded, and clears stale_w[j]; reads behave the same way via stale_r/m_rready.
- Stale blocking: a new transaction targeting a channel whose stale bit is set waits in ISSUE, with m_*valid low, until the bit clears. This wait is counted by the timeout.
- Unselected channels have m_*valid=0. m_*addr/data/strb are broadcast from the held registers to all channels.
- Only one m_*valid bit is high per path at any time.
- Reset values: all valid outputs 0; s_bresp/s_rresp = 2'b00; s_rdata = 0; all stale bits 0; s_awready = s_wready = s_arready = 1 combinationally once out of reset (0 while reset_n_i is low).
- Reset mid-transaction: all state is discarded; no response is produced.

Test Plan:
1. Write with AW and W in the same cycle, addr 0x0000_0204, N=4 -> m_awvalid=4'b0100 next cycle; after m_bvalid[2] with OKAY, s_bvalid with bresp 00 one cycle later.
2. W arrives 3 cycles before AW, addr 0x0000_0010 -> W is held and s_wready is low until AW; channel 0 is issued only after both are held; OKAY response.
3. Read of 0x0000_0500 (N=4) -> no m_arvalid; s_rvalid next cycle with rresp 11 and rdata 0xDEADBEEF.
4. timeout_p=8; read to channel 1 where m_arready is asserted but m_rvalid never arrives -> s_rvalid with rresp 10 after 8 cycles; stale_r[1] set.
5. Continuing from scenario 4, m_rvalid[1] arrives late -> it is consumed, s_rvalid is not asserted, stale_r[1] clears. A following read to channel 1 then completes OKAY.
6. Concurrent write to channel 3 and read to channel 0 with s_bready/s_rready held low for 5 cycles -> both responses are held stable; reset_n_i pulsed low mid-hold -> all valids go to 0 immediately.
